// File: rtl/expr_recognizer_if.sv
// Character-stream bus for the expression recognizer.
// The source drives in_valid/in, and the recognizer returns its status flags.
interface expr_recognizer_if #(
    parameter int DEPTH_W = 3
) ();
    // Handshake: in is consumed on a rising clk edge when in_valid=1.
    // There is no ready signal because the recognizer never stalls.
    logic               in_valid;
    logic [7:0]         in;
    logic               out;
    logic               err;
    logic [DEPTH_W-1:0] depth;

    modport master (output in_valid, output in, input out, input err, input depth);
    modport slave  (input in_valid, input in, output out, output err, output depth);
endinterface

// File: rtl/expr_recognizer.sv
// Streaming recognizer for expr := term (op term)*, term := number | '(' expr ')'.
// out means the prefix accepted so far is a complete legal expression. err is sticky until clr.
module expr_recognizer #(
    parameter int MAX_DIGITS = 3,
    parameter int MAX_DEPTH  = 4,
    parameter int EXT_OPS    = 0,
    parameter int DEPTH_W    = 3
) (
    input  logic             clk,
    input  logic             clr,
    expr_recognizer_if.slave bus,
    output logic [1:0]       state_o
);
    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [DCNT_W-1:0]  MAX_DIG_C = DCNT_W'(MAX_DIGITS);
    localparam logic [DEPTH_W-1:0] MAX_DEP_C = DEPTH_W'(MAX_DEPTH);

    typedef enum logic [1:0] {S_EXP, S_NUM, S_CLS, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;

    logic is_dig, is_op, is_lp, is_rp;

    always_comb begin
        is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_op  = (bus.in == 8'h2B) || (bus.in == 8'h2A) ||
                 ((EXT_OPS != 0) && ((bus.in == 8'h2D) || (bus.in == 8'h2F)));
        is_lp  = (bus.in == 8'h28);
        is_rp  = (bus.in == 8'h29);
    end

    // Any transition into S_ERR leaves dcnt and depth untouched so they freeze at pre-error values.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        depth_d = depth_q;
        if (bus.in_valid) begin
            case (state_q)
                S_EXP: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        dcnt_d  = DCNT_W'(1);
                    end else if (is_lp && (depth_q < MAX_DEP_C)) begin
                        depth_d = depth_q + 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_dig && (dcnt_q < MAX_DIG_C)) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end else if (is_op) begin
                        state_d = S_EXP;
                        dcnt_d  = '0;
                    end else if (is_rp && (depth_q != '0)) begin
                        state_d = S_CLS;
                        dcnt_d  = '0;
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_CLS: begin
                    if (is_op) begin
                        state_d = S_EXP;
                    end else if (is_rp && (depth_q != '0)) begin
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_EXP;
            dcnt_q  <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            depth_q <= depth_d;
        end
    end

    assign bus.out   = ((state_q == S_NUM) || (state_q == S_CLS)) && (depth_q == '0);
    assign bus.err   = (state_q == S_ERR);
    assign bus.depth = depth_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_expr_recognizer.sv
// Bench for expr_recognizer: three parameter variants share one character stream.
// Each variant is checked against a prefix-rescanning reference model.
module tb_expr_recognizer;
    logic       clk;
    logic       clr;
    logic       tb_valid;
    logic [7:0] tb_char;
    logic [1:0] st_a, st_b, st_c;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] str_q[$];

    // a: defaults; b: extended operators; c: nesting limited to 2
    expr_recognizer_if #(.DEPTH_W(3)) ifa ();
    expr_recognizer_if #(.DEPTH_W(3)) ifb ();
    expr_recognizer_if #(.DEPTH_W(2)) ifc ();

    assign ifa.in_valid = tb_valid;
    assign ifa.in       = tb_char;
    assign ifb.in_valid = tb_valid;
    assign ifb.in       = tb_char;
    assign ifc.in_valid = tb_valid;
    assign ifc.in       = tb_char;

    expr_recognizer #(.MAX_DIGITS(3), .MAX_DEPTH(4), .EXT_OPS(0), .DEPTH_W(3)) dut_a (
        .clk(clk), .clr(clr), .bus(ifa), .state_o(st_a));
    expr_recognizer #(.MAX_DIGITS(3), .MAX_DEPTH(4), .EXT_OPS(1), .DEPTH_W(3)) dut_b (
        .clk(clk), .clr(clr), .bus(ifb), .state_o(st_b));
    expr_recognizer #(.MAX_DIGITS(3), .MAX_DEPTH(2), .EXT_OPS(0), .DEPTH_W(2)) dut_c (
        .clk(clk), .clr(clr), .bus(ifc), .state_o(st_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int C_NONE = 0, C_DIG = 1, C_OP = 2, C_LP = 3, C_RP = 4, C_ILL = 5;

    function automatic int classify(input logic [7:0] c, input bit ext);
        if (c >= 8'h30 && c <= 8'h39) return C_DIG;
        if (c == 8'h2B || c == 8'h2A) return C_OP;
        if (ext && (c == 8'h2D || c == 8'h2F)) return C_OP;
        if (c == 8'h28) return C_LP;
        if (c == 8'h29) return C_RP;
        return C_ILL;
    endfunction

    // Rescan the whole accepted prefix: find the first char that breaks the grammar.
    function automatic void ref_eval(input int max_dig, input int max_dep, input bit ext,
                                     output bit r_out, output bit r_err, output int r_depth);
        int bal = 0;
        int run = 0;
        int prev = C_NONE;
        int cls;
        bit ok;
        r_err = 1'b0;
        foreach (str_q[i]) begin
            cls = classify(str_q[i], ext);
            case (prev)
                C_NONE, C_OP, C_LP: ok = (cls == C_DIG) || (cls == C_LP);
                C_DIG:              ok = (cls == C_DIG) || (cls == C_OP) || (cls == C_RP);
                default:            ok = (cls == C_OP) || (cls == C_RP);
            endcase
            if (cls == C_DIG) begin
                run++;
                if (run > max_dig) ok = 1'b0;
            end else begin
                run = 0;
            end
            if (cls == C_LP && bal >= max_dep) ok = 1'b0;
            if (cls == C_RP && bal == 0) ok = 1'b0;
            if (!ok) begin
                r_err = 1'b1;
                break;
            end
            if (cls == C_LP) bal++;
            if (cls == C_RP) bal--;
            prev = cls;
        end
        r_depth = bal;
        r_out = !r_err && (str_q.size() > 0) && (prev == C_DIG || prev == C_RP) && (bal == 0);
    endfunction

    function automatic logic [7:0] pick_char();
        int r = $urandom_range(0, 99);
        if (r < 45) return 8'h30 + 8'($urandom_range(0, 9));
        if (r < 60) return ($urandom_range(0, 1) != 0) ? 8'h2B : 8'h2A;
        if (r < 68) return ($urandom_range(0, 1) != 0) ? 8'h2D : 8'h2F;
        if (r < 82) return 8'h28;
        if (r < 96) return 8'h29;
        return ($urandom_range(0, 1) != 0) ? 8'h78 : 8'h20;
    endfunction

    task automatic drive(input logic v, input logic [7:0] c);
        @(negedge clk);
        tb_valid = v;
        tb_char  = c;
        @(posedge clk);
        #1;
        if (v) str_q.push_back(c);
    endtask

    task automatic do_clr();
        @(negedge clk);
        tb_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
        str_q.delete();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tb_valid = 1'b0;
        tb_char = 8'h00;
        #3;
        n_checks++;
        if ({ifa.out, ifa.err, ifa.depth} !== 5'b0 || {ifb.out, ifb.err, ifb.depth} !== 5'b0 ||
            {ifc.out, ifc.err, ifc.depth} !== 4'b0) begin
            n_errors++;
            $display("FAIL reset: got a=%b b=%b c=%b, want all zero",
                     {ifa.out, ifa.err, ifa.depth}, {ifb.out, ifb.err, ifb.depth}, {ifc.out, ifc.err, ifc.depth});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        str_q.delete();
    endtask

    task automatic test_simple_sum();
        string s = "12+3";
        bit exp_out[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i]);
            n_checks++;
            if (ifa.out !== exp_out[i] || ifa.err !== 1'b0) begin
                n_errors++;
                $display("FAIL sum[%0d]: got out=%b err=%b, want out=%b err=0", i, ifa.out, ifa.err, exp_out[i]);
            end
        end
    endtask

    task automatic test_brackets();
        string s = "(1+2)*3";
        int exp_dep[7] = '{1, 1, 1, 1, 0, 0, 0};
        bit exp_out[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i]);
            n_checks++;
            if (ifa.depth !== 3'(exp_dep[i]) || ifa.out !== exp_out[i] || ifa.err !== 1'b0) begin
                n_errors++;
                $display("FAIL brackets[%0d]: got depth=%0d out=%b err=%b, want depth=%0d out=%b err=0",
                         i, ifa.depth, ifa.out, ifa.err, exp_dep[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_digit_limit();
        string s = "1234+5";
        bit exp_out[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bit exp_err[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i]);
            n_checks++;
            if (ifa.out !== exp_out[i] || ifa.err !== exp_err[i] || ifa.depth !== 3'd0) begin
                n_errors++;
                $display("FAIL digits[%0d]: got out=%b err=%b depth=%0d, want out=%b err=%b depth=0",
                         i, ifa.out, ifa.err, ifa.depth, exp_out[i], exp_err[i]);
            end
        end
    endtask

    task automatic test_ext_ops();
        do_clr();
        drive(1'b1, 8'h35);
        drive(1'b1, 8'h2D);
        n_checks++;
        if (ifa.err !== 1'b1 || ifb.err !== 1'b0 || ifb.out !== 1'b0) begin
            n_errors++;
            $display("FAIL ext_minus: got a.err=%b b.err=%b b.out=%b, want 1 0 0", ifa.err, ifb.err, ifb.out);
        end
        drive(1'b1, 8'h32);
        n_checks++;
        if (ifa.err !== 1'b1 || ifa.out !== 1'b0 || ifb.err !== 1'b0 || ifb.out !== 1'b1) begin
            n_errors++;
            $display("FAIL ext_operand: got a.err=%b a.out=%b b.err=%b b.out=%b, want 1 0 0 1",
                     ifa.err, ifa.out, ifb.err, ifb.out);
        end
    endtask

    task automatic test_depth_limits();
        do_clr();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'h28);
            n_checks++;
            if (ifc.err !== (i == 3) || ifc.depth !== 2'((i < 3) ? i : 2) || ifa.depth !== 3'(i) || ifa.err !== 1'b0) begin
                n_errors++;
                $display("FAIL depth_open[%0d]: got c.err=%b c.depth=%0d a.depth=%0d a.err=%b, want %b %0d %0d 0",
                         i, ifc.err, ifc.depth, ifa.depth, ifa.err, i == 3, (i < 3) ? i : 2, i);
            end
        end
        do_clr();
        drive(1'b1, 8'h29);
        n_checks++;
        if (ifa.err !== 1'b1 || ifa.depth !== 3'd0 || ifc.err !== 1'b1 || ifc.depth !== 2'd0 || ifa.out !== 1'b0) begin
            n_errors++;
            $display("FAIL depth_underflow: got a.err=%b a.depth=%0d c.err=%b c.depth=%0d a.out=%b, want 1 0 1 0 0",
                     ifa.err, ifa.depth, ifc.err, ifc.depth, ifa.out);
        end
    endtask

    task automatic test_gaps_and_clr();
        do_clr();
        drive(1'b1, 8'h37);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 8'h29);
            n_checks++;
            if (ifa.out !== 1'b1 || ifa.err !== 1'b0) begin
                n_errors++;
                $display("FAIL gap_num[%0d]: got out=%b err=%b, want out=1 err=0", g, ifa.out, ifa.err);
            end
        end
        drive(1'b1, 8'h2B);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 8'h35);
            n_checks++;
            if (ifa.out !== 1'b0 || ifa.err !== 1'b0) begin
                n_errors++;
                $display("FAIL gap_op[%0d]: got out=%b err=%b, want out=0 err=0", g, ifa.out, ifa.err);
            end
        end
        drive(1'b1, 8'h28);
        drive(1'b1, 8'h29);
        n_checks++;
        if (ifa.err !== 1'b1 || ifa.depth !== 3'd1) begin
            n_errors++;
            $display("FAIL frozen_err: got err=%b depth=%0d, want err=1 depth=1", ifa.err, ifa.depth);
        end
        @(negedge clk);
        tb_valid = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        n_checks++;
        if (ifa.out !== 1'b0 || ifa.err !== 1'b0 || ifa.depth !== 3'd0) begin
            n_errors++;
            $display("FAIL async_clr: got out=%b err=%b depth=%0d, want 0 0 0", ifa.out, ifa.err, ifa.depth);
        end
        #1;
        clr = 1'b0;
        str_q.delete();
        drive(1'b1, 8'h35);
        n_checks++;
        if (ifa.out !== 1'b1 || ifa.err !== 1'b0) begin
            n_errors++;
            $display("FAIL after_clr: got out=%b err=%b, want out=1 err=0", ifa.out, ifa.err);
        end
        // clr held across an edge with a valid digit: the digit must be dropped.
        @(negedge clk);
        tb_valid = 1'b1;
        tb_char = 8'h35;
        clr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ifa.out !== 1'b0 || ifa.err !== 1'b0 || ifa.depth !== 3'd0) begin
            n_errors++;
            $display("FAIL clr_wins: got out=%b err=%b depth=%0d, want 0 0 0", ifa.out, ifa.err, ifa.depth);
        end
        @(negedge clk);
        clr = 1'b0;
        tb_valid = 1'b0;
        str_q.delete();
    endtask

    task automatic test_random();
        bit ro, re;
        int rd;
        int len;
        logic v;
        for (int seq = 0; seq < 60; seq++) begin
            do_clr();
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                v = ($urandom_range(0, 3) != 0);
                drive(v, pick_char());
                ref_eval(3, 4, 1'b0, ro, re, rd);
                n_checks++;
                if ({ifa.out, ifa.err, ifa.depth} !== {ro, re, 3'(rd)}) begin
                    n_errors++;
                    $display("FAIL rand_a[%0d.%0d]: got out/err/depth=%b, want %b",
                             seq, k, {ifa.out, ifa.err, ifa.depth}, {ro, re, 3'(rd)});
                end
                ref_eval(3, 4, 1'b1, ro, re, rd);
                n_checks++;
                if ({ifb.out, ifb.err, ifb.depth} !== {ro, re, 3'(rd)}) begin
                    n_errors++;
                    $display("FAIL rand_b[%0d.%0d]: got out/err/depth=%b, want %b",
                             seq, k, {ifb.out, ifb.err, ifb.depth}, {ro, re, 3'(rd)});
                end
                ref_eval(3, 2, 1'b0, ro, re, rd);
                n_checks++;
                if ({ifc.out, ifc.err, ifc.depth} !== {ro, re, 2'(rd)}) begin
                    n_errors++;
                    $display("FAIL rand_c[%0d.%0d]: got out/err/depth=%b, want %b",
                             seq, k, {ifc.out, ifc.err, ifc.depth}, {ro, re, 2'(rd)});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simple_sum();
        test_brackets();
        test_digit_limit();
        test_ext_ops();
        test_depth_limits();
        test_gaps_and_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
